// File: rtl/he_pkg.sv
// he_pkg: shared constants, counter-width check and sequencer state
// encoding for the histogram-equalization controller.
package he_pkg;

  localparam int unsigned NUM_BINS         = 256;
  localparam int unsigned DEF_IMAGE_WIDTH  = 660;
  localparam int unsigned DEF_IMAGE_HEIGHT = 440;
  localparam int unsigned NUM_PIXELS       = DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT;
  localparam int unsigned DEF_CNT_W        = 19;

  // True when a cnt_w-bit counter can hold a full-frame pixel count.
  function automatic bit cnt_w_fits(input int unsigned cnt_w, input int unsigned num_pixels);
    return (64'd1 << cnt_w) > 64'(num_pixels);
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DRAIN,
    SCAN_RD,
    SCAN_ACC,
    SCAN_DIV,
    SCAN_EMIT
  } he_state_e;

endpackage

// File: rtl/he_div.sv
// he_div: 8-iteration restoring divider. The caller guarantees the
// quotient fits in 8 bits, so the partial remainder starts from the
// numerator's upper CNT_W bits and one quotient bit is produced per cycle.
module he_div #(
  parameter int unsigned CNT_W = 19
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [CNT_W+7:0]   num_i,
  input  logic [CNT_W-1:0]   den_i,
  output logic               busy_o,
  output logic [7:0]         quo_o
);

  logic [CNT_W-1:0] rem_q;
  logic [7:0]       low_q;
  logic [CNT_W-1:0] den_q;
  logic [7:0]       quo_q;
  logic [3:0]       cnt_q;
  logic             busy_q;

  logic [CNT_W:0]   trial;
  logic [CNT_W-1:0] diff;
  logic             take;

  // Shift in the next numerator bit and trial-subtract the divisor.
  always_comb begin
    trial = {rem_q, low_q[7]};
    take  = (trial >= {1'b0, den_q});
    diff  = trial[CNT_W-1:0] - den_q;
  end

  // Load on start, then iterate until eight quotient bits are formed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      low_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= num_i[CNT_W+7:8];
      low_q  <= num_i[7:0];
      den_q  <= den_i;
      quo_q  <= '0;
      cnt_q  <= 4'd8;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q  <= take ? diff : trial[CNT_W-1:0];
      low_q  <= {low_q[6:0], 1'b0};
      quo_q  <= {quo_q[6:0], take};
      cnt_q  <= cnt_q - 4'd1;
      if (cnt_q == 4'd1) busy_q <= 1'b0;
    end
  end

  assign busy_o = busy_q;
  assign quo_o  = quo_q;

endmodule

// File: rtl/he_ctrl.sv
// he_ctrl: frame sequencer for histogram equalization. Clears the
// external histogram RAM, accumulates one frame through a forwarded
// read-modify-write pipeline, then scans bins into a CDF and streams an
// 8-bit transformation table.
// Optional build macro HE_CDFMIN_EN: subtract the first non-zero CDF value
// before scaling (classic cdf_min equalization).
module he_ctrl
  import he_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int unsigned IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [7:0]       pix_data,
  output logic [7:0]       hist_raddr,
  input  logic [CNT_W-1:0] hist_rdata,
  output logic             hist_we,
  output logic [7:0]       hist_waddr,
  output logic [CNT_W-1:0] hist_wdata,
  output logic             tbl_valid,
  output logic [7:0]       tbl_addr,
  output logic [7:0]       tbl_data,
  output logic             done
);

  localparam int unsigned       NPIX     = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam logic [CNT_W-1:0]  NPIX_C   = CNT_W'(NPIX);
  localparam logic [7:0]        LAST_BIN = 8'(NUM_BINS - 1);

  if (!cnt_w_fits(CNT_W, NPIX) || !cnt_w_fits(DEF_CNT_W, NUM_PIXELS)) begin : g_cnt_w_check
    $error("he_ctrl: CNT_W too narrow for the frame pixel count");
  end

  he_state_e        state_q;
  logic             busy_q;
  logic             done_q;
  logic             tbl_valid_q;
  logic [7:0]       tbl_addr_q;
  logic [7:0]       bin_q;
  logic [2:0]       div_cnt_q;
  logic [CNT_W-1:0] pix_cnt_q;
  logic [CNT_W-1:0] cdf_q;
  // read-modify-write pipeline: stage B address and the previous write
  logic             a_vld_q;
  logic [7:0]       a_addr_q;
  logic             p_vld_q;
  logic [7:0]       p_addr_q;
  logic [CNT_W-1:0] p_data_q;
`ifdef HE_CDFMIN_EN
  logic [CNT_W-1:0] cdf_min_q;
  logic             min_seen_q;
  logic             zero_q;
  logic             uni_q;
  logic [7:0]       first_pix_q;
  logic [CNT_W-1:0] min_eff;
`endif

  logic             pix_hs;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] b_wdata;
  logic [CNT_W-1:0] cdf_nx;
  logic [CNT_W-1:0] scale_in;
  logic [CNT_W+7:0] scale_ext;
  logic [CNT_W+7:0] div_num;
  logic [CNT_W-1:0] div_den;
  logic             div_start;
  logic             div_busy;
  logic [7:0]       div_quo;

  // The RAM has no read-during-write bypass: a write issued on the
  // immediately preceding cycle to the same bin is not yet visible in
  // hist_rdata, so the increment base comes from that write instead.
  always_comb begin
    pix_ready = (state_q == ACCUM) && (pix_cnt_q < NPIX_C);
    pix_hs    = pix_valid && pix_ready;
    base      = (p_vld_q && (p_addr_q == a_addr_q)) ? p_data_q : hist_rdata;
    b_wdata   = base + CNT_W'(1);
  end

  // Histogram RAM port drive for clear, accumulate and scan phases.
  always_comb begin
    hist_raddr = '0;
    hist_we    = 1'b0;
    hist_waddr = '0;
    hist_wdata = '0;
    if (state_q == CLEAR) begin
      hist_we    = 1'b1;
      hist_waddr = bin_q;
    end
    if (a_vld_q) begin
      hist_we    = 1'b1;
      hist_waddr = a_addr_q;
      hist_wdata = b_wdata;
    end
    if (pix_hs) begin
      hist_raddr = pix_data;
    end else if (state_q == SCAN_RD) begin
      hist_raddr = bin_q;
    end
  end

  // Running CDF and divider operands, consumed in SCAN_ACC.
  always_comb begin
    cdf_nx = cdf_q + hist_rdata;
`ifdef HE_CDFMIN_EN
    min_eff  = min_seen_q ? cdf_min_q : cdf_nx;
    scale_in = cdf_nx - min_eff;
    div_den  = NPIX_C - min_eff;
`else
    scale_in = cdf_nx;
    div_den  = NPIX_C;
`endif
    scale_ext = {8'd0, scale_in};
    div_num   = (scale_ext << 8) - scale_ext;
    div_start = (state_q == SCAN_ACC) && !div_busy;
  end

  he_div #(
    .CNT_W (CNT_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (reset),
    .start_i (div_start),
    .num_i   (div_num),
    .den_i   (div_den),
    .busy_o  (div_busy),
    .quo_o   (div_quo)
  );

  // Sequencer, accumulate pipeline and registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tbl_valid_q <= 1'b0;
      tbl_addr_q  <= '0;
      bin_q       <= '0;
      div_cnt_q   <= '0;
      pix_cnt_q   <= '0;
      cdf_q       <= '0;
      a_vld_q     <= 1'b0;
      a_addr_q    <= '0;
      p_vld_q     <= 1'b0;
      p_addr_q    <= '0;
      p_data_q    <= '0;
`ifdef HE_CDFMIN_EN
      cdf_min_q   <= '0;
      min_seen_q  <= 1'b0;
      zero_q      <= 1'b0;
      uni_q       <= 1'b0;
      first_pix_q <= '0;
`endif
    end else begin
      done_q      <= 1'b0;
      tbl_valid_q <= 1'b0;
      tbl_addr_q  <= '0;
      a_vld_q     <= pix_hs;
      if (pix_hs) a_addr_q <= pix_data;
      p_vld_q     <= a_vld_q;
      p_addr_q    <= a_addr_q;
      p_data_q    <= b_wdata;

      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= CLEAR;
            busy_q     <= 1'b1;
            bin_q      <= '0;
            pix_cnt_q  <= '0;
            cdf_q      <= '0;
`ifdef HE_CDFMIN_EN
            cdf_min_q  <= '0;
            min_seen_q <= 1'b0;
            uni_q      <= 1'b0;
`endif
          end
        end
        CLEAR: begin
          bin_q <= bin_q + 8'd1;
          if (bin_q == LAST_BIN) state_q <= ACCUM;
        end
        ACCUM: begin
          if (pix_hs) begin
            pix_cnt_q <= pix_cnt_q + CNT_W'(1);
`ifdef HE_CDFMIN_EN
            // A single-valued frame makes the scaled denominator zero; it
            // must be known before bin 0 is emitted, so track it here.
            if (pix_cnt_q == '0) begin
              first_pix_q <= pix_data;
              uni_q       <= 1'b1;
            end else if (pix_data != first_pix_q) begin
              uni_q <= 1'b0;
            end
`endif
            if (pix_cnt_q == NPIX_C - CNT_W'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          state_q <= SCAN_RD;
        end
        SCAN_RD: begin
          state_q <= SCAN_ACC;
        end
        SCAN_ACC: begin
          cdf_q     <= cdf_nx;
          div_cnt_q <= '0;
          state_q   <= SCAN_DIV;
`ifdef HE_CDFMIN_EN
          zero_q <= (cdf_nx == '0);
          if (!min_seen_q && (cdf_nx != '0)) begin
            min_seen_q <= 1'b1;
            cdf_min_q  <= cdf_nx;
          end
`endif
        end
        SCAN_DIV: begin
          div_cnt_q <= div_cnt_q + 3'd1;
          if (div_cnt_q == 3'd7) begin
            state_q     <= SCAN_EMIT;
            tbl_valid_q <= 1'b1;
            tbl_addr_q  <= bin_q;
          end
        end
        SCAN_EMIT: begin
          bin_q <= bin_q + 8'd1;
          if (bin_q == LAST_BIN) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= SCAN_RD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Table value: divider quotient, or the cdf_min special cases.
  always_comb begin
    tbl_data = '0;
    if (tbl_valid_q) begin
`ifdef HE_CDFMIN_EN
      if (uni_q)       tbl_data = tbl_addr_q;
      else if (zero_q) tbl_data = '0;
      else             tbl_data = div_quo;
`else
      tbl_data = div_quo;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign tbl_valid = tbl_valid_q;
  assign tbl_addr  = tbl_addr_q;

endmodule

// File: tb/tb_he_ctrl.sv
// tb_he_ctrl: scoreboard bench for he_ctrl on a reduced 16x8 frame.
module tb_he_ctrl;

  localparam int unsigned W  = 16;
  localparam int unsigned H  = 8;
  localparam int unsigned NP = W * H;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          pix_valid = 1'b0;
  logic [7:0]    pix_data = '0;
  logic          busy, pix_ready, hist_we, tbl_valid, done;
  logic [7:0]    hist_raddr, hist_waddr, tbl_addr, tbl_data;
  logic [CW-1:0] hist_rdata, hist_wdata;

  he_ctrl #(
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .CNT_W        (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .hist_raddr (hist_raddr),
    .hist_rdata (hist_rdata),
    .hist_we    (hist_we),
    .hist_waddr (hist_waddr),
    .hist_wdata (hist_wdata),
    .tbl_valid  (tbl_valid),
    .tbl_addr   (tbl_addr),
    .tbl_data   (tbl_data),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned addr;
    int unsigned data;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          e;
  int unsigned   n_checks = 0, n_pass = 0;
  int unsigned   cyc = 0, hs_count = 0, n_strobe = 0, last_strobe = 0;
  logic [CW-1:0] mem [256];
  logic          scramble = 1'b0;
  logic [7:0]    pix [NP];
  int unsigned   ref_hist [256];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Simple dual-port RAM, registered read, no read-during-write bypass.
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < 256; i++) mem[i] <= CW'($urandom);
    end else begin
      hist_rdata <= mem[hist_raddr];
      if (hist_we) mem[hist_waddr] <= hist_wdata;
    end
  end

  // Monitor: handshake counting and table scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (reset && pix_valid && pix_ready) hs_count++;
    if (tbl_valid) begin
      if (exp_q.size() == 0) begin
        chk("tbl_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("tbl_addr", tbl_addr, e.addr);
        chk("tbl_data", tbl_data, e.data);
      end
      if (n_strobe != 0) chk("tbl_spacing", cyc - last_strobe, 11);
      last_strobe = cyc;
      n_strobe++;
    end
  end

  // Reference: histogram by counting, CDF by summing, then the mapping rule.
  task automatic model();
    int unsigned cdf, q;
`ifdef HE_CDFMIN_EN
    int unsigned mn;
    bit uni;
    mn = 0;
    uni = 1'b0;
`endif
    cdf = 0;
    for (int b = 0; b < 256; b++) ref_hist[b] = 0;
    for (int i = 0; i < NP; i++) ref_hist[pix[i]]++;
`ifdef HE_CDFMIN_EN
    for (int b = 0; b < 256; b++) if (ref_hist[b] == NP) uni = 1'b1;
`endif
    for (int b = 0; b < 256; b++) begin
      cdf += ref_hist[b];
`ifdef HE_CDFMIN_EN
      if (mn == 0 && cdf != 0) mn = cdf;
      if (uni) q = b;
      else if (cdf == 0) q = 0;
      else q = (cdf - mn) * 255 / (NP - mn);
`else
      q = cdf * 255 / NP;
`endif
      exp_q.push_back('{addr: b, data: q});
    end
  endtask

  // One full frame; entered and left at #1 after a rising edge.
  task automatic run_frame(input int unsigned gap_pct, input bit poke);
    int unsigned bad, idx, budget, t;
    bit v, hs, poked;
    model();
    n_strobe = 0;
    hs_count = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    bad = 0;
    for (int unsigned i = 0; i < 256; i++) begin
      if (!(hist_we && hist_waddr == 8'(i) && hist_wdata == '0)) bad++;
      @(posedge clk); #1;
    end
    chk("clear_bad_cycles", bad, 0);
    idx = 0; budget = 0; poked = 1'b0;
    while (idx < NP && budget < 20000) begin
      v = ($urandom_range(0, 99) >= gap_pct);
      pix_valid = v;
      pix_data  = v ? pix[idx] : 8'($urandom);
      start = 1'b0;
      if (poke && !poked && idx == NP / 2) begin
        start = 1'b1;
        poked = 1'b1;
      end
      hs = v && pix_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      budget++;
    end
    start = 1'b0;
    chk("feed_complete", idx, NP);
    pix_valid = 1'b1;
    pix_data  = 8'hAA;
    t = 0;
    while (!done && t < 5000) begin
      start = (poke && t == 200);
      @(posedge clk); #1;
      t++;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 0);
    pix_valid = 1'b0;
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("tbl_strobes", n_strobe, 256);
    chk("exp_left", exp_q.size(), 0);
    chk("handshakes", hs_count, NP);
    bad = 0;
    for (int b = 0; b < 256; b++) if (int'(mem[b]) != ref_hist[b]) bad++;
    chk("hist_bad_bins", bad, 0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 0, expected 1");
    $fatal(1);
  end

  initial begin
    scramble = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    scramble = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_tbl_valid", tbl_valid, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of accumulation.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (256) begin
      @(posedge clk); #1;
    end
    pix_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      pix_data = 8'($urandom);
      @(posedge clk); #1;
    end
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pix_ready", pix_ready, 0);
    chk("mid_rst_hist_we", hist_we, 0);
    chk("mid_rst_hist_raddr", hist_raddr, 0);
    chk("mid_rst_hist_waddr", hist_waddr, 0);
    chk("mid_rst_hist_wdata", hist_wdata, 0);
    chk("mid_rst_tbl_valid", tbl_valid, 0);
    chk("mid_rst_tbl_addr", tbl_addr, 0);
    chk("mid_rst_tbl_data", tbl_data, 0);
    chk("mid_rst_done", done, 0);
    pix_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Constant frame of 128.
    for (int i = 0; i < NP; i++) pix[i] = 8'd128;
    run_frame(0, 1'b0);

    // Half 0, half 255.
    for (int i = 0; i < NP; i++) pix[i] = (i < NP / 2) ? 8'd0 : 8'd255;
    run_frame(20, 1'b0);

    // Long run of identical pixels, no gaps: exercises forwarding.
    for (int i = 0; i < NP; i++) pix[i] = (i < 64) ? 8'd7 : 8'd9;
    run_frame(0, 1'b0);
    chk("hist7", mem[7], 64);
    chk("hist9", mem[9], NP - 64);

    // Clustered values with gaps and stray start pulses.
    for (int i = 0; i < NP; i++) pix[i] = 8'($urandom_range(40, 47));
    run_frame(30, 1'b1);

    // Full-range random values.
    for (int i = 0; i < NP; i++) pix[i] = 8'($urandom);
    run_frame(10, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/he_ctrl.md
Name: he_ctrl

Overview:
- Frame-level sequencer for the histogram-equalization engine.
- Clears an external 256-bin histogram RAM, then accumulates one frame of 8-bit pixels through a read-modify-write pipeline.
- Scans the bins to build the CDF, scales each CDF value to 8 bits with a small sequential divider, and streams the 256-entry transformation table to the pixel-mapping stage.

Parameters:
IMAGE_WIDTH, 660, pixels per line
IMAGE_HEIGHT, 440, lines per frame
CNT_W, 19, histogram/CDF counter width; must satisfy 2^CNT_W > IMAGE_WIDTH*IMAGE_HEIGHT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a frame when idle
busy  out  1  high from accepted start until the done pulse
pix_valid  in  1  pixel present
pix_ready  out  1  high only in ACCUM while count < NUM_PIXELS
pix_data  in  8  pixel value
hist_raddr  out  8  histogram RAM read address; rdata valid next cycle
hist_rdata  in  CNT_W  histogram RAM read data
hist_we  out  1  histogram RAM write enable
hist_waddr  out  8  histogram RAM write address
hist_wdata  out  CNT_W  histogram RAM write data
tbl_valid  out  1  one-cycle strobe per table entry; no backpressure
tbl_addr  out  8  table index (bin)
tbl_data  out  8  equalized value for bin tbl_addr
done  out  1  one-cycle pulse after tbl entry 255

Behaviour:
- Reset (async, active-low): state IDLE; all outputs, counters, cdf, cdf_min and pipeline registers return to 0.
- IDLE: start=1 moves to CLEAR next cycle. start is ignored in every other state.
- CLEAR: 256 cycles with hist_we=1, hist_waddr=0..255, hist_wdata=0, then ACCUM.
- ACCUM:
  - pix_ready=1 until NUM_PIXELS = IMAGE_WIDTH*IMAGE_HEIGHT handshakes (pix_valid & pix_ready) have been counted.
  - Stage A, handshake cycle: hist_raddr=pix_data, address registered.
  - Stage B, next cycle: hist_we=1, hist_waddr=registered address, hist_wdata=base+1.
  - base = hist_rdata, except when stage B's address equals the previous stage-B write address on the immediately preceding cycle; then base = previous hist_wdata (forwarding). The RAM is simple dual-port with no read-during-write bypass.
  - pix_valid gaps are allowed; bubbles do not break forwarding correctness.
  - After the final pixel, pix_ready drops the next cycle. The final stage-B write completes, then the state moves to SCAN.
- SCAN, per bin k = 0..255, exactly 11 cycles:
  - RD (1 cycle): hist_raddr=k.
  - ACC (1 cycle): cdf += hist_rdata.
  - DIV (8 cycles): he_div computes floor(num/den), 8-bit quotient, one bit per cycle.
  - EMIT (1 cycle): tbl_valid=1, tbl_addr=k, tbl_data=quotient.
  - Default mapping: num = cdf*255 (CNT_W+8 bits), den = NUM_PIXELS. Bin 255 always yields 255.
  - First tbl_valid occurs 11 cycles after SCAN entry; spacing is fixed at 11 cycles.
- After EMIT for k=255: done=1 for one cycle, busy=0 the same cycle, state IDLE. cdf and cdf_min clear on the next start.
- Arithmetic: all unsigned. cdf saturation is impossible by the CNT_W constraint. Quotient is guaranteed ≤255.
- Reset mid-operation: abandon the frame immediately. The histogram RAM contents are don't-care; the next frame re-clears them.

Optional Feature:
HE_CDFMIN_EN
- Defined:
  - cdf_min is latched at the first bin whose cdf ≠ 0.
  - Bins with cdf=0 emit 0.
  - Other bins: num = (cdf-cdf_min)*255, den = NUM_PIXELS-cdf_min.
  - If den=0 (single-valued image), each bin emits tbl_data=k (identity) with the same 11-cycle timing.
- Undefined: cdf_min logic is absent; default mapping only.

Decomposition:
- Package he_pkg holds:
  - NUM_BINS=256
  - NUM_PIXELS
  - the CNT_W check
  - state encoding: IDLE, CLEAR, ACCUM, DRAIN, SCAN_RD, SCAN_ACC, SCAN_DIV, SCAN_EMIT
- Sub-module he_div: 8-iteration restoring divider with start/busy/quotient. Inputs are a (CNT_W+8)-bit numerator and a CNT_W-bit denominator; quotient is 8 bits.

Test Plan:
- Reset asserted mid-ACCUM (pixel 1000): all outputs are 0 immediately; the next start restarts with 256 CLEAR writes; busy=1.
- Constant frame, all pixels 128, macro undefined: tbl_data=0 for bins 0..127 and 255 for bins 128..255; exactly 256 tbl_valid strobes 11 cycles apart; then done.
- Constant frame 128, HE_CDFMIN_EN defined: tbl_data equals the bin index k for all 256 entries.
- Half 0 / half 255 frame, macro undefined: bins 0..254 give 127, bin 255 gives 255. With the macro defined: bin 0 gives 0, bins 1..254 give 0, bin 255 gives 255.
- Back-to-back identical pixels (value 7, 1000 consecutive, no gaps), rest value 9: final hist[7]=1000 and hist[9]=NUM_PIXELS-1000 via the RAM model (checks forwarding).
- Random pix_valid gaps and a start pulse while busy: the start is ignored; pix_ready never exceeds NUM_PIXELS handshakes; the table matches the reference-model CDF computation.
